npu_instr_queue: RTL and testbench
==================================

NPU_INSTR_QUEUE -- requirements
Module: npu_instr_queue

Interface
REQ-001 SHALL have parameter W_IN, default 8, instruction width matching the scheduler `instr` input.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 8, repeat-count width.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock.
REQ-005 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port `in_valid`, input, 1 bit: host offers an instruction entry.
REQ-007 SHALL have port `in_ready`, output, 1 bit: queue can accept an entry.
REQ-008 SHALL have port `in_instr`, input, W_IN bits: opcode to queue.
REQ-009 SHALL have port `in_repeat`, input, CNT_W bits: extra issues (entry issued in_repeat+1 times).
REQ-010 SHALL have port `start`, input, 1 bit: begin or resume issuing.
REQ-011 SHALL have port `halt`, input, 1 bit: pause issuing.
REQ-012 SHALL have port `flush`, input, 1 bit: discard all queued and in-progress work.
REQ-013 SHALL have port `instr`, output, W_IN bits: registered opcode to `npu_scheduler`.
REQ-014 SHALL have port `instr_valid`, output, 1 bit: `instr` holds a real issued opcode, not filler.
REQ-015 SHALL have port `busy`, output, 1 bit: FSM not in IDLE.
REQ-016 SHALL have port `done`, output, 1 bit: one-cycle pulse when END is issued.
REQ-017 SHALL have port `level`, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-018 SHALL accept an entry {in_instr, in_repeat} on an edge where in_valid && in_ready && !flush.
REQ-019 SHALL drive in_ready = (level < DEPTH); at full, no push SHALL occur even if a pop occurs on the same edge.
REQ-020 SHALL NOT bypass: an entry pushed on edge E becomes poppable at edge E+1, and appears on `instr` after edge E+1 at the earliest.
REQ-021 SHALL implement FSM states IDLE, RUN and PAUSE.
REQ-022 In IDLE, `start` SHALL move the FSM to RUN.
REQ-023 In RUN, `halt` SHALL move the FSM to PAUSE.
REQ-024 In PAUSE, `start` SHALL return the FSM to RUN.
REQ-025 When `start` and `halt` are asserted together, `halt` SHALL win.
REQ-026 Per edge in RUN, priority 1: if rpt_left > 0, SHALL reissue the current opcode and decrement rpt_left.
REQ-027 Per edge in RUN, priority 2: otherwise, if the FIFO is non-empty, SHALL pop the head, drive its opcode and load rpt_left = head repeat.
REQ-028 Per edge in RUN, priority 3: otherwise SHALL drive NOP with instr_valid=0 (starvation, FSM stays in RUN).
REQ-029 In IDLE and PAUSE, `instr` SHALL be NOP with instr_valid=0; PAUSE SHALL preserve rpt_left and the current opcode.
REQ-030 A popped END opcode SHALL be driven for exactly one cycle, its repeat field ignored, with done=1 that cycle; the FSM SHALL then enter IDLE with remaining FIFO contents kept.
REQ-031 `flush` SHALL empty the FIFO, clear rpt_left, drive NOP, enter IDLE, and take priority over push, pop, start and halt on the same edge.
REQ-032 `level` SHALL be updated after each edge; a simultaneous push and pop SHALL leave it unchanged.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH, with an extra wrap bit distinguishing full from empty.

Reset
REQ-034 On rst_n=1, asynchronously: FIFO empty, level=0, state IDLE, instr=NOP, instr_valid=0, busy=0, done=0, rpt_left=0.
REQ-035 Reset mid-operation SHALL discard all entries.
REQ-036 After reset release, in_ready=1.

Structure
REQ-037 Package `npu_pkg` SHALL hold the NOP (8'h00) and END (8'hFF) opcode constants and the FSM state enum.
REQ-038 SHALL instantiate one sub-module, `npu_instr_fifo`: a synchronous FIFO with push, pop, flush, full, empty and level.

Verification
REQ-039 Push {0x11,r=0},{0x22,r=2}, then start -> instr sequence 0x11,0x22,0x22,0x22, then NOP with instr_valid=0.
REQ-040 Fill 8 entries without start -> in_ready=0 and level=8; a 9th in_valid is not accepted; after start, in_ready=1 the cycle after the first pop.
REQ-041 halt during the 2nd repeat of {0x33,r=3}, then start after 4 cycles -> NOPs while paused, then exactly 2 more 0x33 issues.
REQ-042 Queue {0x44,0},{0xFF,5},{0x55,0}, start -> 0x44, then 0xFF with done=1 for one cycle, then IDLE with level=1.
REQ-043 flush together with in_valid and start during a repeat -> level=0, IDLE, instr=NOP, and the offered entry is dropped.
REQ-044 Assert rst_n mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared opcode constants and issue-FSM state encoding for the
//               NPU instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam logic [7:0] c_nop_op = 8'h00;
    localparam logic [7:0] c_end_op = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } npu_state_e;

endpackage
`default_nettype wire

// File: rtl/npu_instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : npu_instr_fifo
// Description : Synchronous FIFO with flush and occupancy output.
//               Pointers carry one extra wrap bit to separate full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/npu_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : npu_instr_queue
// Description : Instruction queue feeding npu_scheduler; issues each entry
//               (repeat+1) times under an IDLE/RUN/PAUSE control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_instr_queue
    import npu_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W_IN-1:0]          in_instr,
    input  logic [CNT_W-1:0]         in_repeat,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     flush,
    output logic [W_IN-1:0]          instr,
    output logic                     instr_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              c_ent_w   = W_IN + CNT_W;
    localparam logic [W_IN-1:0] c_nop     = W_IN'(c_nop_op);
    localparam logic [W_IN-1:0] c_end     = W_IN'(c_end_op);
    localparam logic [CNT_W-1:0] c_rpt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    npu_state_e         r_state;
    logic [W_IN-1:0]    r_cur;
    logic [W_IN-1:0]    r_instr;
    logic [CNT_W-1:0]   r_rpt_left;
    logic               r_instr_valid;
    logic               r_done;

    logic               w_full;
    logic               w_empty;
    logic [c_ent_w-1:0] w_head;
    logic [W_IN-1:0]    w_head_instr;
    logic [CNT_W-1:0]   w_head_rpt;
    logic               w_push;
    logic               w_pop;
    logic               w_issue_slot;

    assign w_head_instr = w_head[c_ent_w-1:CNT_W];
    assign w_head_rpt   = w_head[CNT_W-1:0];

    assign w_issue_slot = (r_state == ST_RUN) && !halt && !flush;
    assign w_pop        = w_issue_slot && (r_rpt_left == '0) && !w_empty;
    assign w_push       = in_valid && !w_full && !flush;

    npu_instr_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (flush),
        .i_wr_data ({in_instr, in_repeat}),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state       <= ST_IDLE;
            r_cur         <= c_nop;
            r_instr       <= c_nop;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
            r_rpt_left    <= '0;
        end else if (flush) begin
            r_state       <= ST_IDLE;
            r_instr       <= c_nop;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
            r_rpt_left    <= '0;
        end else begin
            r_instr       <= c_nop;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !halt) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_PAUSE;
                    end else if (r_rpt_left != '0) begin
                        r_instr       <= r_cur;
                        r_instr_valid <= 1'b1;
                        r_rpt_left    <= r_rpt_left - c_rpt_one;
                    end else if (!w_empty) begin
                        r_instr       <= w_head_instr;
                        r_instr_valid <= 1'b1;
                        // END issues once regardless of its repeat field and stops the queue.
                        if (w_head_instr == c_end) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cur      <= w_head_instr;
                            r_rpt_left <= w_head_rpt;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start && !halt) r_state <= ST_RUN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = !w_full;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign done        = r_done;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_npu_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_instr_queue
// Description : Scoreboard bench for npu_instr_queue with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_instr_queue;

    localparam int W_IN  = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [W_IN-1:0]  in_instr = '0;
    logic [CNT_W-1:0] in_repeat = '0;
    logic             start = 1'b0;
    logic             halt = 1'b0;
    logic             flush = 1'b0;
    logic             in_ready;
    logic [W_IN-1:0]  instr;
    logic             instr_valid;
    logic             busy;
    logic             done;
    logic [LW-1:0]    level;

    npu_instr_queue #(.W_IN(W_IN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_repeat   (in_repeat),
        .start       (start),
        .halt        (halt),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .level       (level)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] cyc; logic [7:0] op; logic dn; } exp_t;
    typedef struct packed { logic [7:0] op; logic [31:0] rpt; } ent_t;
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_e;

    exp_t        exp_q[$];
    ent_t        m_q[$];
    mstate_e     m_state = M_IDLE;
    int unsigned m_rpt = 0;
    logic [7:0]  m_cur = 8'h00;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model of the upcoming clock edge.
    task automatic model_step(input bit iv, input logic [7:0] op, input int unsigned rp,
                              input bit st, input bit hl, input bit fl);
        bit   take;
        ent_t e;
        if (fl) begin
            m_q.delete();
            m_rpt   = 0;
            m_state = M_IDLE;
            return;
        end
        take = iv && (m_q.size() < DEPTH);
        if (m_state == M_RUN && hl) begin
            m_state = M_PAUSE;
        end else if (m_state == M_RUN) begin
            if (m_rpt > 0) begin
                m_rpt--;
                exp_q.push_back('{cyc + 1, m_cur, 1'b0});
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                if (e.op == 8'hFF) begin
                    exp_q.push_back('{cyc + 1, 8'hFF, 1'b1});
                    m_state = M_IDLE;
                end else begin
                    exp_q.push_back('{cyc + 1, e.op, 1'b0});
                    m_cur = e.op;
                    m_rpt = e.rpt;
                end
            end
        end else if (st && !hl) begin
            m_state = M_RUN;
        end
        if (take) m_q.push_back('{op, rp});
    endtask

    task automatic drive(input bit iv, input logic [7:0] op, input int unsigned rp,
                         input bit st, input bit hl, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_instr  = op;
        in_repeat = rp[CNT_W-1:0];
        start     = st;
        halt      = hl;
        flush     = fl;
        model_step(iv, op, rp, st, hl, fl);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"},    instr,       32'h0);
        check({tag, "_valid"},    instr_valid, 32'h0);
        check({tag, "_busy"},     busy,        32'h0);
        check({tag, "_done"},     done,        32'h0);
        check({tag, "_level"},    level,       32'h0);
        check({tag, "_in_ready"}, in_ready,    32'h1);
    endtask

    // Monitor: per-edge status checks plus scoreboard pop on every issued opcode.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("level", level, m_q.size());
            check("in_ready", in_ready, (m_q.size() < DEPTH) ? 32'h1 : 32'h0);
            check("busy", busy, (m_state != M_IDLE) ? 32'h1 : 32'h0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_issue: got nothing, expected op %0h at edge %0d", e.op, e.cyc);
            end
            if (instr_valid) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got op %0h done %0b at edge %0d, expected none",
                             instr, done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", instr, e.op);
                    check("done", done, e.dn);
                end
            end else begin
                check("filler_instr", instr, 32'h0);
                check("filler_done", done, 32'h0);
            end
        end
    end

    initial begin
        logic [7:0] op;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b0;

        // Two entries, second repeated twice.
        drive(1, 8'h11, 0, 0, 0, 0);
        drive(1, 8'h22, 2, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(8);

        // Fill to capacity, ninth offer is refused, then drain.
        for (int i = 0; i < DEPTH; i++) drive(1, 8'h60 + 8'(i), 0, 0, 0, 0);
        drive(1, 8'h99, 0, 0, 0, 0);
        idle(2);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(DEPTH + 4);

        // Halt after the second issue of a 4-issue entry, resume later.
        drive(1, 8'h33, 3, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(2);
        drive(0, 8'h00, 0, 0, 1, 0);
        idle(4);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(6);

        // END stops the queue with the trailing entry still queued.
        drive(1, 8'h44, 0, 0, 0, 0);
        drive(1, 8'hFF, 5, 0, 0, 0);
        drive(1, 8'h55, 0, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(6);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(3);

        // Flush with a simultaneous offer and start during a repeat.
        drive(1, 8'h77, 5, 0, 0, 0);
        drive(1, 8'h78, 0, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(3);
        drive(1, 8'h88, 0, 1, 0, 1);
        idle(4);

        // Asynchronous reset in the middle of a repeat.
        drive(1, 8'h99, 9, 0, 0, 0);
        drive(1, 8'h9A, 0, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        idle(3);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        #2;
        rst_n = 1'b1;
        m_q.delete();
        exp_q.delete();
        m_rpt   = 0;
        m_state = M_IDLE;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            op = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            drive($urandom_range(0, 1) == 1, op,
                  ($urandom_range(0, 15) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0);
        end

        // Drain whatever remains, restarting after each END.
        repeat (200) drive(0, 8'h00, 0, 1, 0, 0);
        idle(2);
        @(posedge clk);
        #2;
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
